mux2_8bit_ctrl: RTL and testbench

- Upstream control and operand stage for the 2:1 8-bit byte multiplexer.
- Captures two 8-bit operands serially from one input bus and holds them on registered d0/d1.
- Sequences the select line s through a programmed pattern for a fixed run length.
- Flags busy while a run is active and pulses done at the end; its d0/d1/s outputs drive the multiplexer's inputs directly.

---
 rtl/mux2_8bit_ctrl.sv | 100 ++++++++++
 tb/tb_mux2_8bit_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mux2_8bit_ctrl.sv
// Operand capture and select sequencer feeding a 2:1 byte multiplexer.
// Two operands arrive serially on din; a run then steps s through a mode-selected pattern.
module mux2_8bit_ctrl #(
  parameter int PERIOD = 4,
  parameter int NPHASE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       load,
  input  logic       start,
  input  logic [1:0] mode,
  output logic [7:0] d0,
  output logic [7:0] d1,
  output logic       s,
  output logic       busy,
  output logic       done,
  output logic       loaded
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(PERIOD - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(NPHASE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic          ptr;
  logic [CW-1:0] cyc_cnt;
  logic [PW-1:0] ph_cnt;
  logic [1:0]    mode_r;

  // Mode 11 picks whichever operand is larger so the mux passes the maximum.
  function automatic logic init_sel(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      2'b01:   return 1'b1;
      2'b11:   return (b > a);
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      d0      <= '0;
      d1      <= '0;
      s       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      loaded  <= 1'b0;
      ptr     <= 1'b0;
      cyc_cnt <= '0;
      ph_cnt  <= '0;
      mode_r  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && loaded) begin
            state   <= RUN;
            busy    <= 1'b1;
            cyc_cnt <= '0;
            ph_cnt  <= '0;
            mode_r  <= mode;
            s       <= init_sel(mode, d0, d1);
          end else if (load) begin
            if (!ptr) begin
              d0  <= din;
              ptr <= 1'b1;
            end else begin
              d1     <= din;
              ptr    <= 1'b0;
              loaded <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            // The final wrap ends the run without a last toggle.
            if (ph_cnt == PH_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
              if (mode_r == 2'b10) s <= ~s;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_8bit_ctrl.sv
// Bench for mux2_8bit_ctrl: table of single-cycle vectors plus full-run sequences,
// expectations queued at drive time and popped when the outputs are sampled.
module tb_mux2_8bit_ctrl;

  localparam int PERIOD = 4;
  localparam int NPHASE = 8;
  localparam int RUNLEN = PERIOD * NPHASE;

  logic       clk = 1'b0;
  logic       reset, load, start;
  logic [7:0] din;
  logic [1:0] mode;
  logic [7:0] d0, d1;
  logic       s, busy, done, loaded;

  always #5 clk = ~clk;

  mux2_8bit_ctrl #(.PERIOD(PERIOD), .NPHASE(NPHASE)) dut (
    .clk(clk), .reset(reset), .din(din), .load(load), .start(start), .mode(mode),
    .d0(d0), .d1(d1), .s(s), .busy(busy), .done(done), .loaded(loaded)
  );

  typedef struct {
    logic       rst;
    logic       ld;
    logic       st;
    logic [7:0] din;
    logic [1:0] md;
    logic [7:0] e_d0;
    logic [7:0] e_d1;
    logic       e_s;
    logic       e_busy;
    logic       e_done;
    logic       e_loaded;
  } vec_t;

  vec_t sbq[$];
  int   total  = 0;
  int   passed = 0;
  int   stepno = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step=%0d actual=%h expected=%h", nm, stepno, act, exp);
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    reset = v.rst; load = v.ld; start = v.st; din = v.din; mode = v.md;
    sbq.push_back(v);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("d0", d0, e.e_d0);
    chk("d1", d1, e.e_d1);
    chk("s", {7'd0, s}, {7'd0, e.e_s});
    chk("busy", {7'd0, busy}, {7'd0, e.e_busy});
    chk("done", {7'd0, done}, {7'd0, e.e_done});
    chk("loaded", {7'd0, loaded}, {7'd0, e.e_loaded});
    stepno++;
  endtask

  // One accepted run plus its DONE cycle and the first idle cycle after it.
  // While busy, load/start are held high with din=FF to prove they are ignored.
  task automatic do_run(input logic [1:0] m, input logic [7:0] e0, input logic [7:0] e1,
                        input logic s0, input logic tog, input logic acc_ld,
                        input logic [7:0] mx, input int abort_at);
    vec_t v;
    for (int k = 0; k <= RUNLEN + 1; k++) begin
      v.rst = 1'b0; v.md = m;
      v.ld = 1'b0; v.st = 1'b0; v.din = 8'h00;
      if (k == 0) begin
        v.st = 1'b1; v.ld = acc_ld; v.din = 8'h55;
      end else if (k <= RUNLEN) begin
        v.st = 1'b1; v.ld = 1'b1; v.din = 8'hFF;
      end
      v.e_d0 = e0; v.e_d1 = e1; v.e_loaded = 1'b1;
      v.e_busy = (k < RUNLEN);
      v.e_done = (k == RUNLEN);
      if (tog) v.e_s = (k < RUNLEN) ? logic'((k / PERIOD) % 2) : 1'b1;
      else     v.e_s = s0;
      if (k == abort_at) begin
        v = '{1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        step(v);
        break;
      end
      step(v);
      if (k == 0 && m == 2'b11) chk("mux_max", s ? d1 : d0, mx);
    end
  endtask

  vec_t tbl[5];
  vec_t idle0;

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; din = 8'h00; mode = 2'b00;
    //          rst  ld   st   din    md     d0     d1     s    busy done loaded
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h3C, 2'b01, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 2'b01, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'hA5, 2'b00, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h77, 2'b00, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    foreach (tbl[i]) step(tbl[i]);

    do_run(2'b10, 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, -1);

    step('{1'b0, 1'b1, 1'b0, 8'h80, 2'b00, 8'h80, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1});
    step('{1'b0, 1'b1, 1'b0, 8'h7F, 2'b00, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1});
    do_run(2'b11, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h80, -1);

    step('{1'b0, 1'b1, 1'b0, 8'h10, 2'b00, 8'h10, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1});
    step('{1'b0, 1'b1, 1'b0, 8'hF0, 2'b00, 8'h10, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1});
    do_run(2'b11, 8'h10, 8'hF0, 1'b1, 1'b0, 1'b0, 8'hF0, -1);

    // Start with a simultaneous load: the load must be dropped.
    do_run(2'b00, 8'h10, 8'hF0, 1'b0, 1'b0, 1'b1, 8'h00, -1);

    // Reset in the middle of a run aborts it; done must never pulse afterwards.
    do_run(2'b01, 8'h10, 8'hF0, 1'b1, 1'b0, 1'b0, 8'h00, 10);
    idle0 = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3 * PERIOD; i++) step(idle0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
